// File: rtl/mux16_rr_scheduler.sv
// Round-robin owner scheduler for a shared 16:1 single-bit mux.
// Drives the mux select and a one-hot grant; grants end on release, withdrawal or hold limit.
module mux16_rr_scheduler #(
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_req,
  input  logic        i_release,
  output logic [3:0]  o_s,
  output logic [15:0] o_gnt,
  output logic        o_gnt_valid,
  output logic        o_timeout
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t      r_state;
  logic [3:0]  r_s;
  logic [15:0] r_gnt;
  logic        r_gnt_valid;
  logic        r_timeout;
  logic [3:0]  r_ptr;
  logic [7:0]  r_hold_cnt;

  logic [31:0] w_req_dbl;
  logic [15:0] w_rot;
  logic [3:0]  w_off;
  logic        w_found;
  logic [3:0]  w_win;
  logic        w_any;
  logic        w_owner_done;
  logic        w_others;
  logic        w_at_limit;

  // Rotate requests so the pointer lands on bit 0; the first set bit is the winner offset.
  always_comb begin
    w_req_dbl = {i_req, i_req} >> r_ptr;
    w_rot     = w_req_dbl[15:0];
    w_off     = 4'd0;
    w_found   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!w_found && w_rot[i]) begin
        w_off   = 4'(i);
        w_found = 1'b1;
      end
    end
    w_win = r_ptr + w_off;
  end

  assign w_any        = |i_req;
  assign w_owner_done = i_release || !i_req[r_s];
  assign w_others     = |(i_req & ~r_gnt);
  assign w_at_limit   = (r_hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_s         <= 4'd0;
      r_gnt       <= 16'd0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_ptr       <= 4'd0;
      r_hold_cnt  <= 8'd0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state     <= ST_GRANT;
            r_s         <= w_win;
            r_gnt       <= 16'd1 << w_win;
            r_gnt_valid <= 1'b1;
            r_hold_cnt  <= 8'd0;
          end
        end
        ST_GRANT: begin
          // Owner-driven endings win over the hold limit and suppress the timeout pulse.
          if (w_owner_done || (w_at_limit && w_others)) begin
            r_state     <= ST_IDLE;
            r_gnt       <= 16'd0;
            r_gnt_valid <= 1'b0;
            r_ptr       <= r_s + 4'd1;
            r_timeout   <= !w_owner_done;
          end else if (!w_at_limit) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_s         = r_s;
  assign o_gnt       = r_gnt;
  assign o_gnt_valid = r_gnt_valid;
  assign o_timeout   = r_timeout;

endmodule

// File: doc/mux16_rr_scheduler.md
# mux16_rr_scheduler

Round-robin scheduler that shares the 16:1 single-bit multiplexer among 16 requesters. It drives the mux's 4-bit select bus and issues a one-hot grant. Each grant lasts until the owner releases it or until a hold limit expires while others are waiting. It sits directly in front of the 16:1 mux select input: requester k's data is wired to mux input I[k].

## Interface
- MAX_HOLD, default 8: maximum grant length in cycles when another requester is pending. Legal range 1–255.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- req  input  16  request per requester; level, held until served.
- release  input  1  current owner finished; sampled only while gnt_valid=1.
- S  output  4  select to the 16:1 mux; equals the index of the current owner.
- gnt  output  16  one-hot grant, bit S set while gnt_valid=1; all zero otherwise.
- gnt_valid  output  1  a grant is active; mux output Y is valid for requester S.
- timeout  output  1  one-cycle pulse when a grant ends by the hold limit.

## Operation
- FSM with two states, both registered:
  - IDLE: gnt_valid=0, gnt=0.
  - GRANT: gnt_valid=1.
- Priority pointer ptr (4 bits). The winner is the first k in order ptr, ptr+1, …, 15, 0, …, ptr−1 with req[k]=1.
- IDLE with any req set:
  - At the next edge: S←winner, gnt←one-hot(winner), enter GRANT, hold_cnt←0.
- IDLE with req=0: remain IDLE. S holds its last value.
- GRANT, per cycle: hold_cnt←hold_cnt+1, saturating at MAX_HOLD−1.
- A grant ends at the next edge when any of the following holds:
  - (a) release=1.
  - (b) req[S]=0 (owner withdrew).
  - (c) hold_cnt==MAX_HOLD−1 and any other req bit (not S) is 1. This is the timeout; timeout=1 in the cycle after that edge.
- On grant end:
  - Next state is IDLE, ptr←S+1 mod 16 (15 wraps to 0), gnt←0, gnt_valid←0.
  - S keeps the ended owner's index.
- Simultaneous end conditions: (a)/(b) take precedence over (c). timeout is not pulsed if release or req[S]=0 coincides with the limit.
- If no other requester is pending, the hold limit does not end the grant; the owner keeps the mux indefinitely.
- A new request arriving during GRANT does not preempt; it waits for the next IDLE arbitration.
- Reset (asynchronous, any state, including mid-grant):
  - State→IDLE, S=0, gnt=0, gnt_valid=0, timeout=0, ptr=0, hold_cnt=0.
  - Takes effect immediately on rst_n falling, without waiting for clk.
  - First arbitration occurs at the first clk edge after rst_n rises, with req set.

## Timing
- Grant latency: req sampled high in IDLE at edge E means gnt_valid=1 and S valid immediately after E (one cycle from request to grant).
- Each grant has exactly one IDLE cycle after it, which is the mux settle gap. Minimum grant-to-grant spacing is grant length + 1 cycle.
- Back-to-back: release at edge E puts IDLE in cycle E..E+1. The next winner is granted after edge E+1.
- A grant under timeout lasts exactly MAX_HOLD cycles with gnt_valid=1.
- S, gnt and gnt_valid change only on clk edges, or on asynchronous reset, and are glitch-free registered outputs.
- timeout width is exactly one cycle, aligned with the first IDLE cycle.

## Test plan
- Reset: drive rst_n=0 mid-grant with no clk edge -> S=0, gnt=0, gnt_valid=0, timeout=0 immediately. After release with req=16'h0001 -> S=0, gnt=16'h0001 one edge later.
- Single requester: req=16'h0020 held, release pulsed after 3 grant cycles -> S=5, gnt_valid high 3 cycles, one IDLE cycle, then re-grant S=5.
- Full rotation: req=16'hFFFF, release asserted on every grant's first cycle -> S sequence 0,1,2,…,15,0 with a one-cycle gap each. Confirms wrap 15→0.
- Timeout: MAX_HOLD=8, req=16'h8001, no release -> owner 0 holds 8 cycles, timeout pulses once, then S=15 is granted. Check also a lone requester with no release -> no timeout, grant persists more than 20 cycles.
- Precedence: release and the hold limit coincide with another req pending -> grant ends, timeout stays 0, ptr advances.
- Withdrawal and mid-grant arrival: owner S=3 drops req[3] while req[2] rises mid-grant -> grant ends next edge with no preemption before that. Next winner is 2 only if no req in 4..15 is set.
